// File: rtl/otter_mem_pkg.sv
// Shared types for the OTTER main-memory arbiter.
// Holds the FSM state encoding, the grant identity and the byte-offset width
// of a word address.
package otter_mem_pkg;

   typedef enum logic [1:0] {IDLE, I_BURST, D_ACCESS} arb_state_t;

   // Encoding doubles as the bit index into the one-hot grant vector.
   typedef enum logic {GNT_I, GNT_D} gnt_t;

   localparam int BYTE_OFF = 2;

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// Bus bundle between the I-cache refill side, the D-side MEM stage, the
// arbiter and the main-memory port.
// Ports: i_* refill request/response, d_* load/store request/response,
//        m_* single main-memory port.
// master modport: the arbiter. slave modport: requesters plus memory model.
interface otter_mem_arbiter_if #(
   parameter int LINE_WORDS = 8,
   parameter int AW         = 32,
   parameter int DW         = 32
);
   localparam int WW = $clog2(LINE_WORDS);

   // I-cache refill side
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_rvalid;
   logic [WW-1:0] i_word;
   logic [DW-1:0] i_rdata;
   logic          i_done;

   // D-side load/store
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_done;

   // Main-memory port
   logic          m_req;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_ack;
   logic [DW-1:0] m_rdata;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
      output i_rvalid, i_word, i_rdata, i_done, d_rdata, d_done,
             m_req, m_we, m_addr, m_wdata
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
      input  i_rvalid, i_word, i_rdata, i_done, d_rdata, d_done,
             m_req, m_we, m_addr, m_wdata
   );

endinterface

// File: rtl/otter_rr_arb2.sv
// Combinational two-way round-robin pick between I (bit 0) and D (bit 1).
// Ports: i_req requests, i_mask requesters excluded this cycle, i_last side
//        served most recently, o_gnt one-hot grant (all zero when none eligible).
module otter_rr_arb2
   import otter_mem_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic [1:0] i_mask,
   input  gnt_t       i_last,
   output logic [1:0] o_gnt
);

   logic [1:0] w_elig;

   assign w_elig = i_req & ~i_mask;

   always_comb begin
      o_gnt = w_elig;
      // On a tie the side that did not go last wins.
      if (w_elig == 2'b11) begin
         o_gnt = (i_last == GNT_I) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares the OTTER main-memory port between I-cache line refill bursts and
// D-side single-word loads/stores, with round-robin tie breaking.
// Ports: CLK/RST (sync, active-high) plus the bus interface (master side).
module otter_mem_arbiter
   import otter_mem_pkg::*;
#(
   parameter int LINE_WORDS = 8,
   parameter int AW         = 32,
   parameter int DW         = 32
) (
   input  logic                CLK,
   input  logic                RST,
   otter_mem_arbiter_if.master bus
);

   localparam int WW = $clog2(LINE_WORDS);
   localparam int LW = AW - WW - BYTE_OFF;
   localparam logic [WW-1:0] LAST_WORD = WW'(LINE_WORDS - 1);

   // State and registered outputs
   arb_state_t    r_state,    w_state_nxt;
   gnt_t          r_last_gnt, w_last_gnt_nxt;
   logic [WW-1:0] r_word_cnt, w_word_cnt_nxt;
   logic [LW-1:0] r_line_base, w_line_base_nxt;
   logic          r_i_rvalid, w_i_rvalid_nxt;
   logic [WW-1:0] r_i_word,   w_i_word_nxt;
   logic [DW-1:0] r_i_rdata,  w_i_rdata_nxt;
   logic          r_i_done,   w_i_done_nxt;
   logic [DW-1:0] r_d_rdata,  w_d_rdata_nxt;
   logic          r_d_done,   w_d_done_nxt;
   logic          r_m_req,    w_m_req_nxt;
   logic          r_m_we,     w_m_we_nxt;
   logic [AW-1:0] r_m_addr,   w_m_addr_nxt;
   logic [DW-1:0] r_m_wdata,  w_m_wdata_nxt;

   logic [1:0]    w_gnt;
   logic [WW-1:0] w_cnt_inc;
   logic          w_ack;
   logic          w_unused;

   // A requester whose done pulse is out this cycle has not yet had the
   // chance to drop its req, so it must not be granted again.
   otter_rr_arb2 u_rr (
      .i_req  ({bus.d_req, bus.i_req}),
      .i_mask ({r_d_done, r_i_done}),
      .i_last (r_last_gnt),
      .o_gnt  (w_gnt)
   );

   assign w_cnt_inc = r_word_cnt + 1'b1;
   // Ack counts only while a transaction is actually on the port.
   assign w_ack     = bus.m_ack & r_m_req;
   assign w_unused  = &{1'b0, bus.i_addr[WW+BYTE_OFF-1:0], bus.d_addr[BYTE_OFF-1:0]};

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_last_gnt_nxt  = r_last_gnt;
      w_word_cnt_nxt  = r_word_cnt;
      w_line_base_nxt = r_line_base;
      w_i_rvalid_nxt  = 1'b0;
      w_i_word_nxt    = r_i_word;
      w_i_rdata_nxt   = r_i_rdata;
      w_i_done_nxt    = 1'b0;
      w_d_rdata_nxt   = r_d_rdata;
      w_d_done_nxt    = 1'b0;
      w_m_req_nxt     = r_m_req;
      w_m_we_nxt      = r_m_we;
      w_m_addr_nxt    = r_m_addr;
      w_m_wdata_nxt   = r_m_wdata;

      case (r_state)
         IDLE: begin
            if (w_gnt[1]) begin
               w_state_nxt   = D_ACCESS;
               w_m_req_nxt   = 1'b1;
               w_m_we_nxt    = bus.d_we;
               w_m_addr_nxt  = {bus.d_addr[AW-1:BYTE_OFF], {BYTE_OFF{1'b0}}};
               w_m_wdata_nxt = bus.d_wdata;
            end else if (w_gnt[0]) begin
               w_state_nxt     = I_BURST;
               w_m_req_nxt     = 1'b1;
               w_m_we_nxt      = 1'b0;
               w_m_wdata_nxt   = '0;
               w_word_cnt_nxt  = '0;
               w_line_base_nxt = bus.i_addr[AW-1:WW+BYTE_OFF];
               w_m_addr_nxt    = {bus.i_addr[AW-1:WW+BYTE_OFF], {WW{1'b0}}, {BYTE_OFF{1'b0}}};
            end
         end

         I_BURST: begin
            if (w_ack) begin
               w_i_rvalid_nxt = 1'b1;
               w_i_rdata_nxt  = bus.m_rdata;
               w_i_word_nxt   = r_word_cnt;
               if (r_word_cnt == LAST_WORD) begin
                  w_i_done_nxt   = 1'b1;
                  w_m_req_nxt    = 1'b0;
                  w_m_addr_nxt   = '0;
                  w_word_cnt_nxt = '0;
                  w_last_gnt_nxt = GNT_I;
                  w_state_nxt    = IDLE;
               end else begin
                  w_word_cnt_nxt = w_cnt_inc;
                  w_m_addr_nxt   = {r_line_base, w_cnt_inc, {BYTE_OFF{1'b0}}};
               end
            end
         end

         D_ACCESS: begin
            if (w_ack) begin
               w_d_done_nxt   = 1'b1;
               w_d_rdata_nxt  = r_m_we ? '0 : bus.m_rdata;
               w_m_req_nxt    = 1'b0;
               w_m_we_nxt     = 1'b0;
               w_m_addr_nxt   = '0;
               w_m_wdata_nxt  = '0;
               w_last_gnt_nxt = GNT_D;
               w_state_nxt    = IDLE;
            end
         end

         default: begin
            w_state_nxt = IDLE;
            w_m_req_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_last_gnt  <= GNT_I;
         r_word_cnt  <= '0;
         r_line_base <= '0;
         r_i_rvalid  <= 1'b0;
         r_i_word    <= '0;
         r_i_rdata   <= '0;
         r_i_done    <= 1'b0;
         r_d_rdata   <= '0;
         r_d_done    <= 1'b0;
         r_m_req     <= 1'b0;
         r_m_we      <= 1'b0;
         r_m_addr    <= '0;
         r_m_wdata   <= '0;
      end else begin
         r_last_gnt  <= w_last_gnt_nxt;
         r_word_cnt  <= w_word_cnt_nxt;
         r_line_base <= w_line_base_nxt;
         r_i_rvalid  <= w_i_rvalid_nxt;
         r_i_word    <= w_i_word_nxt;
         r_i_rdata   <= w_i_rdata_nxt;
         r_i_done    <= w_i_done_nxt;
         r_d_rdata   <= w_d_rdata_nxt;
         r_d_done    <= w_d_done_nxt;
         r_m_req     <= w_m_req_nxt;
         r_m_we      <= w_m_we_nxt;
         r_m_addr    <= w_m_addr_nxt;
         r_m_wdata   <= w_m_wdata_nxt;
      end
   end

   assign bus.i_rvalid = r_i_rvalid;
   assign bus.i_word   = r_i_word;
   assign bus.i_rdata  = r_i_rdata;
   assign bus.i_done   = r_i_done;
   assign bus.d_rdata  = r_d_rdata;
   assign bus.d_done   = r_d_done;
   assign bus.m_req    = r_m_req;
   assign bus.m_we     = r_m_we;
   assign bus.m_addr   = r_m_addr;
   assign bus.m_wdata  = r_m_wdata;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed testbench for otter_mem_arbiter with 4-word refill lines.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_otter_mem_arbiter;
   import otter_mem_pkg::*;

   logic clk;
   logic rst;
   int   n_run;
   int   n_fail;

   otter_mem_arbiter_if #(.LINE_WORDS(4), .AW(32), .DW(32)) bus ();

   otter_mem_arbiter #(.LINE_WORDS(4), .AW(32), .DW(32)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_quiet();
      bus.i_req   = 1'b0;
      bus.i_addr  = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      bus.m_ack   = 1'b0;
      bus.m_rdata = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_quiet();
      tick();
      tick();
      n_run++; if (bus.m_req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req: got %b want 0", bus.m_req); end
      n_run++; if ({bus.i_rvalid, bus.i_done, bus.d_done, bus.m_we} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 0000", {bus.i_rvalid, bus.i_done, bus.d_done, bus.m_we}); end
      n_run++; if (bus.m_addr !== 32'h0) begin n_fail++; $display("FAIL reset_m_addr: got %h want 0", bus.m_addr); end
      rst = 1'b0;
      tick();
      n_run++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.r_state); end
   endtask

   task automatic test_i_burst();
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h104;
      bus.m_ack  = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         exp_addr = 32'h100 + 32'(4 * k);
         exp_data = 32'hCAFE_0000 + 32'(k);
         n_run++; if (bus.m_req !== 1'b1 || bus.m_we !== 1'b0) begin n_fail++; $display("FAIL burst_req_we w%0d: got req=%b we=%b want req=1 we=0", k, bus.m_req, bus.m_we); end
         n_run++; if (bus.m_addr !== exp_addr) begin n_fail++; $display("FAIL burst_addr w%0d: got %h want %h", k, bus.m_addr, exp_addr); end
         bus.m_rdata = exp_data;
         tick();
         n_run++; if (bus.i_rvalid !== 1'b1 || bus.i_word !== 2'(k) || bus.i_rdata !== exp_data) begin
            n_fail++; $display("FAIL burst_word w%0d: got v=%b idx=%0d d=%h want v=1 idx=%0d d=%h", k, bus.i_rvalid, bus.i_word, bus.i_rdata, k, exp_data);
         end
         n_run++; if (bus.i_done !== (k == 3)) begin n_fail++; $display("FAIL burst_done w%0d: got %b want %b", k, bus.i_done, (k == 3)); end
      end
      n_run++; if (bus.m_req !== 1'b0) begin n_fail++; $display("FAIL burst_end_m_req: got %b want 0", bus.m_req); end
      bus.i_req = 1'b0;
      bus.m_ack = 1'b0;
      tick();
      n_run++; if (bus.i_rvalid !== 1'b0 || bus.i_done !== 1'b0 || bus.m_req !== 1'b0) begin
         n_fail++; $display("FAIL burst_after: got v=%b done=%b req=%b want 000", bus.i_rvalid, bus.i_done, bus.m_req);
      end
   endtask

   task automatic test_d_load();
      int n_done;
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 32'h2000;
      tick();
      n_run++; if (bus.m_req !== 1'b1 || bus.m_we !== 1'b0 || bus.m_addr !== 32'h2000) begin
         n_fail++; $display("FAIL load_issue: got req=%b we=%b addr=%h want 1 0 00002000", bus.m_req, bus.m_we, bus.m_addr);
      end
      n_done = 0;
      for (int w = 0; w < 3; w++) begin
         tick();
         if (bus.d_done === 1'b1) n_done++;
      end
      n_run++; if (n_done != 0 || bus.m_req !== 1'b1) begin n_fail++; $display("FAIL load_wait: got done_count=%0d req=%b want 0 1", n_done, bus.m_req); end
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'hDEAD_BEEF;
      tick();
      n_run++; if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL load_done: got done=%b rdata=%h want 1 deadbeef", bus.d_done, bus.d_rdata);
      end
      bus.d_req = 1'b0;
      bus.m_ack = 1'b0;
      n_done = 0;
      for (int w = 0; w < 3; w++) begin
         tick();
         if (bus.d_done === 1'b1) n_done++;
      end
      n_run++; if (n_done != 0) begin n_fail++; $display("FAIL load_single_done: got %0d extra pulses want 0", n_done); end
   endtask

   task automatic test_d_store();
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h40;
      bus.d_wdata = 32'h1234_5678;
      tick();
      n_run++; if (bus.m_req !== 1'b1 || bus.m_we !== 1'b1 || bus.m_addr !== 32'h40 || bus.m_wdata !== 32'h1234_5678) begin
         n_fail++; $display("FAIL store_issue: got req=%b we=%b addr=%h wd=%h want 1 1 00000040 12345678", bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata);
      end
      // Fields were latched at grant; later input changes must not leak through.
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h80;
      bus.d_wdata = 32'h0;
      tick();
      n_run++; if (bus.m_we !== 1'b1 || bus.m_addr !== 32'h40 || bus.m_wdata !== 32'h1234_5678) begin
         n_fail++; $display("FAIL store_latched: got we=%b addr=%h wd=%h want 1 00000040 12345678", bus.m_we, bus.m_addr, bus.m_wdata);
      end
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'hFFFF_FFFF;
      tick();
      n_run++; if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'h0 || bus.m_req !== 1'b0) begin
         n_fail++; $display("FAIL store_done: got done=%b rdata=%h req=%b want 1 00000000 0", bus.d_done, bus.d_rdata, bus.m_req);
      end
      bus.d_req = 1'b0;
      bus.m_ack = 1'b0;
      tick();
      n_run++; if (bus.d_done !== 1'b0) begin n_fail++; $display("FAIL store_single_done: got %b want 0", bus.d_done); end
   endtask

   task automatic test_spurious_ack();
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'h9999_9999;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_run++; if ({bus.i_rvalid, bus.i_done, bus.d_done, bus.m_req} !== 4'b0) begin
            n_fail++; $display("FAIL spurious_out c%0d: got %b want 0000", c, {bus.i_rvalid, bus.i_done, bus.d_done, bus.m_req});
         end
         n_run++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL spurious_state c%0d: got %0d want IDLE", c, dut.r_state); end
      end
      bus.m_ack = 1'b0;
   endtask

   task automatic test_round_robin();
      logic       seq_is_d [4];
      int         n_gnt;
      logic       prev_req;
      int         n_idone;
      rst = 1'b1;
      drive_quiet();
      tick();
      rst = 1'b0;
      tick();
      bus.i_req   = 1'b1;
      bus.i_addr  = 32'h200;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h300;
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'h7777_7777;
      tick();
      n_run++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h300) begin
         n_fail++; $display("FAIL rr_first_d: got req=%b addr=%h want 1 00000300", bus.m_req, bus.m_addr);
      end
      tick();
      n_run++; if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'h7777_7777) begin
         n_fail++; $display("FAIL rr_best_latency: got done=%b rdata=%h want 1 77777777", bus.d_done, bus.d_rdata);
      end
      seq_is_d[0] = 1'b1;
      for (int i = 1; i < 4; i++) seq_is_d[i] = 1'bx;
      n_gnt    = 1;
      prev_req = bus.m_req;
      for (int c = 0; c < 60 && n_gnt < 4; c++) begin
         tick();
         if (bus.m_req === 1'b1 && prev_req === 1'b0) begin
            seq_is_d[n_gnt] = (bus.m_addr === 32'h300);
            n_gnt++;
         end
         prev_req = bus.m_req;
      end
      n_run++; if (n_gnt != 4) begin n_fail++; $display("FAIL rr_grant_count: got %0d grants want 4", n_gnt); end
      n_run++; if ({seq_is_d[1], seq_is_d[2], seq_is_d[3]} !== 3'b010) begin
         n_fail++; $display("FAIL rr_alternate: got is_d=%b%b%b want 010 (I,D,I)", seq_is_d[1], seq_is_d[2], seq_is_d[3]);
      end
      // Dropping i_req mid-burst is illegal but the burst still runs to the end.
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      n_idone   = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (bus.i_done === 1'b1) n_idone++;
      end
      n_run++; if (n_idone != 1 || bus.m_req !== 1'b0) begin
         n_fail++; $display("FAIL rr_dropped_burst: got i_done_count=%0d req=%b want 1 0", n_idone, bus.m_req);
      end
      bus.m_ack = 1'b0;
   endtask

   task automatic test_rst_mid_burst();
      bus.i_req   = 1'b1;
      bus.i_addr  = 32'h400;
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'h1111_1111;
      tick();
      tick();
      tick();
      n_run++; if (bus.m_addr !== 32'h408 || bus.i_word !== 2'd1) begin
         n_fail++; $display("FAIL rstb_word2: got addr=%h idx=%0d want 00000408 1", bus.m_addr, bus.i_word);
      end
      rst = 1'b1;
      tick();
      n_run++; if ({bus.m_req, bus.m_we, bus.i_rvalid, bus.i_done, bus.d_done} !== 5'b0) begin
         n_fail++; $display("FAIL rstb_ctrl: got %b want 00000", {bus.m_req, bus.m_we, bus.i_rvalid, bus.i_done, bus.d_done});
      end
      n_run++; if (bus.m_addr !== 32'h0 || bus.i_rdata !== 32'h0 || bus.i_word !== 2'd0) begin
         n_fail++; $display("FAIL rstb_data: got addr=%h rdata=%h idx=%0d want 0 0 0", bus.m_addr, bus.i_rdata, bus.i_word);
      end
      rst = 1'b0;
      drive_quiet();
      tick();
      n_run++; if (bus.i_done !== 1'b0 || bus.m_req !== 1'b0) begin
         n_fail++; $display("FAIL rstb_no_done: got done=%b req=%b want 0 0", bus.i_done, bus.m_req);
      end
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h500;
      tick();
      n_run++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h500) begin
         n_fail++; $display("FAIL rstb_d_grant: got req=%b addr=%h want 1 00000500", bus.m_req, bus.m_addr);
      end
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'h55;
      tick();
      n_run++; if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'h55) begin
         n_fail++; $display("FAIL rstb_d_done: got done=%b rdata=%h want 1 00000055", bus.d_done, bus.d_rdata);
      end
      drive_quiet();
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_run  = 0;
      n_fail = 0;
      rst    = 1'b1;
      drive_quiet();
      test_reset();
      test_i_burst();
      test_d_load();
      test_d_store();
      test_spurious_ack();
      test_round_robin();
      test_rst_mid_burst();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
